// File: rtl/board_store.sv
// board_store: 10x20 playfield store with a sequential line-clear engine.
// Ports:
//   CLOCK_50, reset                        clock, async active-high reset
//   board_rx/ry -> board_rdata             combinational read, out of range reads as wall (1)
//   board_we, board_wx/wy, board_wdata     single-cell write, accepted only while idle
//   clear_start -> clear_busy, clear_done  line-clear pass request and status
//   lines_cleared                          rows removed by the last pass
//   vga_x/vga_y -> vga_cell                registered display read, out of range reads 0
module board_store (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] board_rx,
    input  logic [4:0] board_ry,
    output logic       board_rdata,
    input  logic       board_we,
    input  logic [3:0] board_wx,
    input  logic [4:0] board_wy,
    input  logic       board_wdata,
    input  logic       clear_start,
    output logic       clear_busy,
    output logic       clear_done,
    output logic [4:0] lines_cleared,
    input  logic [3:0] vga_x,
    input  logic [4:0] vga_y,
    output logic       vga_cell
);
    localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, SHIFT = 2'd2, DONE = 2'd3;
    logic [9:0] rows [20];
    logic [1:0] state;
    logic [4:0] r;
    logic       rd_in, wr_in, vga_in;
    assign rd_in       = board_rx < 4'd10 && board_ry < 5'd20;
    assign wr_in       = board_wx < 4'd10 && board_wy < 5'd20;
    assign vga_in      = vga_x < 4'd10 && vga_y < 5'd20;
    assign board_rdata = rd_in ? rows[board_ry][board_rx] : 1'b1;
    assign clear_busy  = state == SCAN || state == SHIFT;
    assign clear_done  = state == DONE;
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 20; i++) rows[i] <= '0;
            state         <= IDLE;
            r             <= 5'd19;
            lines_cleared <= '0;
            vga_cell      <= 1'b0;
        end else begin
            vga_cell <= vga_in ? rows[vga_y][vga_x] : 1'b0;
            case (state)
                IDLE: begin
                    if (board_we && wr_in) rows[board_wy][board_wx] <= board_wdata;
                    if (clear_start) begin
                        state         <= SCAN;
                        r             <= 5'd19;
                        lines_cleared <= '0;
                    end
                end
                SCAN: begin
                    if (rows[r] == 10'h3FF) state <= SHIFT;
                    else if (r == 5'd0) state <= DONE;
                    else r <= r - 5'd1;
                end
                SHIFT: begin
                    // r stays put so the row that drops into it is tested next
                    for (int k = 1; k < 20; k++) if (5'(k) <= r) rows[k] <= rows[k-1];
                    rows[0]       <= '0;
                    lines_cleared <= lines_cleared + 5'd1;
                    state         <= SCAN;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_board_store.sv
// tb_board_store: directed and randomized checks of board_store against a row-compaction model.
module tb_board_store;
    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] board_rx = '0, board_wx = '0, vga_x = '0;
    logic [4:0] board_ry = '0, board_wy = '0, vga_y = '0;
    logic       board_we = 1'b0, board_wdata = 1'b0, clear_start = 1'b0;
    logic       board_rdata, clear_busy, clear_done, vga_cell;
    logic [4:0] lines_cleared;
    int         n_assert = 0, n_fail = 0;
    logic [9:0] mrow [20];

    board_store dut (
        .CLOCK_50(CLOCK_50), .reset(reset),
        .board_rx(board_rx), .board_ry(board_ry), .board_rdata(board_rdata),
        .board_we(board_we), .board_wx(board_wx), .board_wy(board_wy), .board_wdata(board_wdata),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .lines_cleared(lines_cleared), .vga_x(vga_x), .vga_y(vga_y), .vga_cell(vga_cell)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic model_cell(input int x, input int y);
        return (x > 9 || y > 19) ? 1'b1 : mrow[y][x];
    endfunction

    task automatic write_cell(input int x, input int y, input logic v);
        board_wx = 4'(x); board_wy = 5'(y); board_wdata = v; board_we = 1'b1;
        tick;
        board_we = 1'b0;
        if (x < 10 && y < 20) mrow[y][x] = v;
    endtask

    task automatic fill_row(input int y, input logic [9:0] val);
        for (int x = 0; x < 10; x++) write_cell(x, y, val[x]);
    endtask

    task automatic check_board(input string tag);
        int errs = 0;
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 10; x++) begin
                board_rx = 4'(x); board_ry = 5'(y);
                #1;
                if (board_rdata !== mrow[y][x]) errs++;
            end
        chk(tag, errs, 0);
    endtask

    task automatic check_read(input string tag, input int x, input int y);
        board_rx = 4'(x); board_ry = 5'(y);
        #1;
        chk(tag, board_rdata, model_cell(x, y));
    endtask

    task automatic check_vga(input string tag, input int x, input int y);
        vga_x = 4'(x); vga_y = 5'(y);
        tick;
        chk(tag, vga_cell, (x > 9 || y > 19) ? 1'b0 : mrow[y][x]);
    endtask

    // Expected result of a pass: keep the non-full rows in order, stacked at the bottom.
    task automatic run_clear(input string tag, input bit poke);
        logic [9:0] exp_rows [20];
        int k = 0, dst = 19, cnt = 0, early = 0;
        for (int y = 19; y >= 0; y--)
            if (mrow[y] == 10'h3FF) k++;
            else begin exp_rows[dst] = mrow[y]; dst--; end
        while (dst >= 0) begin exp_rows[dst] = '0; dst--; end
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        while (clear_busy === 1'b1 && cnt < 100) begin
            if (poke && cnt == 3) begin
                board_wx = 4'd0; board_wy = 5'd0; board_wdata = ~mrow[0][0];
                board_we = 1'b1; clear_start = 1'b1;
            end else begin
                board_we = 1'b0; clear_start = 1'b0;
            end
            if (clear_done === 1'b1) early++;
            cnt++;
            tick;
        end
        board_we = 1'b0; clear_start = 1'b0;
        chk({tag, " busy cycles"}, cnt, 20 + 2 * k);
        chk({tag, " done pulse"}, clear_done, 1'b1);
        chk({tag, " lines_cleared"}, lines_cleared, k);
        mrow = exp_rows;
        tick;
        chk({tag, " done during busy"}, early, 0);
        chk({tag, " done single"}, clear_done, 1'b0);
        chk({tag, " no restart"}, clear_busy, 1'b0);
        chk({tag, " lines hold"}, lines_cleared, k);
        check_board({tag, " board"});
    endtask

    initial begin
        for (int y = 0; y < 20; y++) mrow[y] = '0;
        #1;
        chk("reset busy", clear_busy, 1'b0);
        chk("reset done", clear_done, 1'b0);
        chk("reset lines", lines_cleared, 5'd0);
        chk("reset vga", vga_cell, 1'b0);
        tick;
        tick;
        reset = 1'b0;
        check_board("reset board");

        write_cell(3, 19, 1'b1);
        check_read("read 3,19", 3, 19);
        chk("read 3,19 value", board_rdata, 1'b1);
        check_read("read 4,19", 4, 19);
        check_read("read 10,5 wall", 10, 5);
        chk("read 10,5 value", board_rdata, 1'b1);
        check_read("read 2,20 wall", 2, 20);
        check_vga("vga 3,19", 3, 19);
        check_vga("vga 12,3 oob", 12, 3);
        write_cell(11, 4, 1'b1);
        write_cell(4, 25, 1'b1);
        check_board("oob writes dropped");

        fill_row(19, 10'h3FF);
        write_cell(2, 18, 1'b1);
        run_clear("one row", 1'b0);
        chk("one row 2,19", mrow[19][2], 1'b1);

        fill_row(19, 10'h3FF);
        fill_row(17, 10'h3FF);
        fill_row(18, 10'h1FF);
        run_clear("two rows", 1'b0);
        chk("two rows row19", mrow[19], 10'h1FF);

        fill_row(19, 10'h3FF);
        fill_row(0, 10'h3FF);
        run_clear("busy poke", 1'b1);

        for (int round = 0; round < 6; round++) begin
            int nf, errs;
            for (int i = 0; i < 15; i++)
                write_cell($urandom_range(0, 11), $urandom_range(0, 21), 1'($urandom));
            nf = $urandom_range(0, 3);
            for (int i = 0; i < nf; i++) fill_row($urandom_range(0, 19), 10'h3FF);
            errs = 0;
            for (int i = 0; i < 8; i++) begin
                int x, y;
                x = $urandom_range(0, 15); y = $urandom_range(0, 31);
                board_rx = 4'(x); board_ry = 5'(y);
                #1;
                if (board_rdata !== model_cell(x, y)) errs++;
            end
            chk("random reads", errs, 0);
            check_vga("random vga", $urandom_range(0, 11), $urandom_range(0, 21));
            run_clear("random pass", 1'b0);
        end

        for (int y = 0; y < 20; y++) fill_row(y, 10'h3FF);
        run_clear("full board", 1'b0);
        chk("full board lines", lines_cleared, 5'd20);

        fill_row(19, 10'h3FF);
        fill_row(5, 10'h155);
        clear_start = 1'b1;
        tick;
        clear_start = 1'b0;
        repeat (4) tick;
        chk("midpass busy", clear_busy, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", clear_busy, 1'b0);
        chk("abort done", clear_done, 1'b0);
        chk("abort lines", lines_cleared, 5'd0);
        chk("abort vga", vga_cell, 1'b0);
        for (int y = 0; y < 20; y++) mrow[y] = '0;
        check_board("abort board");
        begin
            int d = 0;
            repeat (3) begin tick; if (clear_done !== 1'b0) d++; end
            chk("abort no done", d, 0);
        end
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        run_clear("post reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
